// File: rtl/pulse_sched_pkg.sv
// Shared types and defaults for the EDM pulse channel scheduler.
// Optional PULSE_STATS_EN adds pulse/short statistics counters in the top.
package pulse_sched_pkg;

  localparam int NCH_DEF           = 4;
  localparam int CNT_W_DEF         = 16;
  localparam int SHORT_OFF_CYC_DEF = 500;

  typedef enum logic [2:0] {
    IDLE,
    DEAD,
    ON,
    OFF,
    SHORT_OFF
  } state_e;

endpackage

// File: rtl/pulse_channel_scheduler_rr_arbiter.sv
// Round-robin channel select: first enabled channel after the
// last-granted pointer; the pointer advances only on a grant.
module rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter  int NCH = NCH_DEF,
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [NCH-1:0] chan_en,
  input  logic           grant,
  output logic [IW-1:0]  next_ch
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    next_ch = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int i = 1; i <= NCH; i++) begin
      idx = IW'((int'(ptr) + i) % NCH);
      if (!found && chan_en[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= IW'(NCH - 1);
    end else if (grant) begin
      ptr <= next_ch;
    end
  end

endmodule

// File: rtl/pulse_channel_scheduler.sv
// Time-multiplexes NCH EDM power channels onto one dead/on/off sequence.
// Define PULSE_STATS_EN to add stats_clr, pulse_cnt and short_cnt.
module pulse_channel_scheduler
  import pulse_sched_pkg::*;
#(
  parameter  int NCH           = NCH_DEF,
  parameter  int SHORT_OFF_CYC = SHORT_OFF_CYC_DEF,
  parameter  int CNT_W         = CNT_W_DEF,
  localparam int IW            = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             power_start,
  input  logic             silk_reach,
  input  logic [NCH-1:0]   chan_en,
  input  logic [CNT_W-1:0] ton,
  input  logic [CNT_W-1:0] ts,
  input  logic [6:0]       dt,
  input  logic             short_flag,
  output logic [NCH-1:0]   gate,
  output logic             cut,
  output logic             busy,
  output logic [IW-1:0]    cur_ch,
  output logic             pulse_done,
  output logic             short_abort
`ifdef PULSE_STATS_EN
  ,
  input  logic             stats_clr,
  output logic [31:0]      pulse_cnt,
  output logic [15:0]      short_cnt
`endif
);

  state_e           state;
  state_e           state_d;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] ton_sh;
  logic [CNT_W-1:0] ts_sh;
  logic [6:0]       dt_sh;
  logic             run;
  logic             grant;
  logic             cnt_clr;
  logic [IW-1:0]    next_ch;
  logic [IW-1:0]    on_ch;
  logic [CNT_W-1:0] dead_last;
  logic [CNT_W-1:0] ton_last;
  logic [CNT_W-1:0] off_last;
  logic [CNT_W-1:0] soff_last;

  assign run = power_start & silk_reach
             & (|chan_en) & (ton != '0);

  assign dead_last = CNT_W'(dt_sh) - CNT_W'(1);
  assign ton_last  = ton_sh - CNT_W'(1);
  // A zero off-time still costs one OFF cycle
  assign off_last  = (ts_sh == '0) ? '0
                   : ts_sh - CNT_W'(1);
  assign soff_last = CNT_W'(SHORT_OFF_CYC - 1);

  rr_arbiter #(.NCH(NCH)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .chan_en (chan_en),
    .grant   (grant),
    .next_ch (next_ch)
  );

  always_comb begin
    state_d     = state;
    cnt_clr     = 1'b0;
    grant       = 1'b0;
    pulse_done  = 1'b0;
    short_abort = 1'b0;
    unique case (state)
      IDLE: grant = run;
      DEAD: begin
        if (!run) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt == dead_last) begin
          state_d = ON;
          cnt_clr = 1'b1;
        end
      end
      ON: begin
        if (short_flag) begin
          state_d     = SHORT_OFF;
          short_abort = 1'b1;
          cnt_clr     = 1'b1;
        end else if (!run) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (cnt == ton_last) begin
          state_d    = OFF;
          pulse_done = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      OFF: begin
        if (cnt == off_last) begin
          state_d = IDLE;
          grant   = run;
          cnt_clr = 1'b1;
        end
      end
      SHORT_OFF: begin
        if (cnt == soff_last) begin
          state_d = IDLE;
          grant   = run;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (grant) begin
      state_d = (dt == '0) ? ON : DEAD;
      cnt_clr = 1'b1;
    end
  end

  assign on_ch = grant ? next_ch : cur_ch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      ton_sh <= '0;
      ts_sh  <= '0;
      dt_sh  <= '0;
      cur_ch <= '0;
      gate   <= '0;
    end else begin
      state <= state_d;
      if (cnt_clr) begin
        cnt <= '0;
      end else if (!(&cnt)) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (grant) begin
        ton_sh <= ton;
        ts_sh  <= ts;
        dt_sh  <= dt;
        cur_ch <= next_ch;
      end
      gate <= (state_d == ON) ? (NCH'(1) << on_ch)
                              : '0;
    end
  end

  assign cut  = (state == SHORT_OFF);
  assign busy = (state != IDLE);

`ifdef PULSE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
      short_cnt <= '0;
    end else if (stats_clr) begin
      pulse_cnt <= '0;
      short_cnt <= '0;
    end else begin
      if (pulse_done && !(&pulse_cnt)) begin
        pulse_cnt <= pulse_cnt + 32'd1;
      end
      if (short_abort && !(&short_cnt)) begin
        short_cnt <= short_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pulse_channel_scheduler.sv
// Bench for pulse_channel_scheduler: table vectors, corner sequences
// and a randomized run against a countdown reference model.
module tb_pulse_channel_scheduler;

  localparam int SOFF = 500;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        power_start = 1'b0;
  logic        silk_reach = 1'b0;
  logic [3:0]  chan_en = '0;
  logic [15:0] ton = '0;
  logic [15:0] ts = '0;
  logic [6:0]  dt = '0;
  logic        short_flag = 1'b0;
  logic [3:0]  gate;
  logic        cut;
  logic        busy;
  logic [1:0]  cur_ch;
  logic        pulse_done;
  logic        short_abort;
`ifdef PULSE_STATS_EN
  logic        stats_clr = 1'b0;
  logic [31:0] pulse_cnt;
  logic [15:0] short_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #10 clk = ~clk;

  pulse_channel_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .power_start (power_start),
    .silk_reach  (silk_reach),
    .chan_en     (chan_en),
    .ton         (ton),
    .ts          (ts),
    .dt          (dt),
    .short_flag  (short_flag),
    .gate        (gate),
    .cut         (cut),
    .busy        (busy),
    .cur_ch      (cur_ch),
    .pulse_done  (pulse_done),
    .short_abort (short_abort)
`ifdef PULSE_STATS_EN
    ,
    .stats_clr   (stats_clr),
    .pulse_cnt   (pulse_cnt),
    .short_cnt   (short_cnt)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s act=timeout exp=event", nm);
  endtask

  function automatic int ch_of(input logic [3:0] g);
    int r = -1;
    for (int i = 3; i >= 0; i--) if (g[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("onehot_gate", 32'($onehot0(gate)), 1);
      chk("gate_cut_excl", 32'(gate != '0 && cut), 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_gate", 32'(gate), 0);
    chk("rst_cut", 32'(cut), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cur_ch", 32'(cur_ch), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct packed {
    logic [3:0]      en;
    logic [15:0]     ton;
    logic [15:0]     ts;
    logic [6:0]      dt;
    logic [7:0]      ncyc;
    logic [7:0]      exp_pd;
    logic [3:0][7:0] exp_on;
    logic [7:0]      exp_np;
    logic [7:0]      exp_first;
    logic [4:0][1:0] exp_ord;
  } vec_t;

  function automatic vec_t mkvec(
    input logic [3:0] en, input int t_on, input int t_s,
    input int d, input int n, input int pd,
    input int on0, input int on1, input int on2, input int on3,
    input int np, input int first,
    input int o0, input int o1, input int o2, input int o3,
    input int o4);
    vec_t v;
    v.en = en; v.ton = 16'(t_on); v.ts = 16'(t_s);
    v.dt = 7'(d); v.ncyc = 8'(n); v.exp_pd = 8'(pd);
    v.exp_on[0] = 8'(on0); v.exp_on[1] = 8'(on1);
    v.exp_on[2] = 8'(on2); v.exp_on[3] = 8'(on3);
    v.exp_np = 8'(np); v.exp_first = 8'(first);
    v.exp_ord[0] = 2'(o0); v.exp_ord[1] = 2'(o1);
    v.exp_ord[2] = 2'(o2); v.exp_ord[3] = 2'(o3);
    v.exp_ord[4] = 2'(o4);
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int pd = 0;
    int np = 0;
    int first = 255;
    int on[4] = '{default: 0};
    int ord[5] = '{default: 0};
    logic [3:0] prev = '0;
    chan_en = v.en; ton = v.ton; ts = v.ts; dt = v.dt;
    power_start = 1'b1; silk_reach = 1'b1; short_flag = 1'b0;
    do_reset();
    for (int s = 0; s < int'(v.ncyc); s++) begin
      @(negedge clk);
      if (pulse_done) pd++;
      for (int c = 0; c < 4; c++) if (gate[c]) on[c]++;
      if (prev == '0 && gate != '0) begin
        if (np < 5) ord[np] = ch_of(gate);
        if (np == 0) first = s;
        np++;
      end
      prev = gate;
    end
    chk($sformatf("v%0d pulse_done_cnt", id), 32'(pd), 32'(v.exp_pd));
    for (int c = 0; c < 4; c++)
      chk($sformatf("v%0d on_cycles_ch%0d", id, c), 32'(on[c]),
          32'(v.exp_on[c]));
    chk($sformatf("v%0d pulses", id), 32'(np), 32'(v.exp_np));
    chk($sformatf("v%0d first_gate", id), 32'(first),
        32'(v.exp_first));
    for (int i = 0; i < int'(v.exp_np) && i < 5; i++)
      chk($sformatf("v%0d order%0d", id, i), 32'(ord[i]),
          32'(v.exp_ord[i]));
  endtask

  // ---------------- hand sequences ----------------
  task automatic pulse(input int ton_at, input int new_ton,
                       input int short_at, input int drop_at,
                       output int ch, output int len,
                       output bit pd_seen, output bit sa_seen);
    int t = 0;
    ch = -1; len = 0; pd_seen = 0; sa_seen = 0;
    while (gate == '0 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (gate == '0) begin
      timeout("pulse_start");
      return;
    end
    ch = ch_of(gate);
    while (gate != '0 && len < 1000) begin
      len++;
      if (len == ton_at) ton = 16'(new_ton);
      if (len == short_at) short_flag = 1'b1;
      if (len == drop_at) silk_reach = 1'b0;
      #1;
      if (pulse_done) pd_seen = 1;
      if (short_abort) sa_seen = 1;
      @(negedge clk);
    end
    short_flag = 1'b0;
  endtask

  // ---------------- reference model ----------------
  typedef enum int {M_IDLE, M_DEAD, M_ON, M_OFF, M_SOFF} mph_t;
  mph_t m_ph;
  int   m_left, m_ptr, m_ch, m_ton, m_ts;
  int   m_pcnt, m_scnt;

  function automatic bit m_run();
    return power_start && silk_reach && chan_en != '0 && ton != '0;
  endfunction

  function automatic bit m_pd();
    return m_ph == M_ON && !short_flag && m_run() && m_left == 1;
  endfunction

  function automatic bit m_sa();
    return m_ph == M_ON && short_flag;
  endfunction

  task automatic m_reset();
    m_ph = M_IDLE; m_left = 0; m_ptr = 3; m_ch = 0;
    m_ton = 0; m_ts = 0; m_pcnt = 0; m_scnt = 0;
  endtask

  task automatic m_grant();
    bit found = 0;
    for (int k = 1; k <= 4; k++) begin
      int c = (m_ptr + k) % 4;
      if (!found && chan_en[c]) begin
        found = 1;
        m_ch = c;
      end
    end
    m_ptr = m_ch;
    m_ton = int'(ton);
    m_ts  = int'(ts);
    if (dt == '0) begin
      m_ph = M_ON; m_left = m_ton;
    end else begin
      m_ph = M_DEAD; m_left = int'(dt);
    end
  endtask

  task automatic m_step(input bit clr);
    bit run = m_run();
    if (clr) begin
      m_pcnt = 0; m_scnt = 0;
    end else begin
      if (m_pd()) m_pcnt++;
      if (m_sa()) m_scnt++;
    end
    case (m_ph)
      M_IDLE: if (run) m_grant();
      M_DEAD: begin
        if (!run) m_ph = M_IDLE;
        else if (m_left == 1) begin m_ph = M_ON; m_left = m_ton; end
        else m_left--;
      end
      M_ON: begin
        if (short_flag) begin m_ph = M_SOFF; m_left = SOFF; end
        else if (!run) m_ph = M_IDLE;
        else if (m_left == 1) begin
          m_ph = M_OFF;
          m_left = (m_ts == 0) ? 1 : m_ts;
        end else m_left--;
      end
      default: begin
        if (m_left == 1) begin
          if (run) m_grant();
          else m_ph = M_IDLE;
        end else m_left--;
      end
    endcase
  endtask

  // ---------------- main ----------------
  vec_t vecs[5];
  int   ch, len;
  bit   pd_seen, sa_seen;
  int   c_cut;
  bit   clr_now;

  initial begin
    vecs[0] = mkvec(4'b0001, 10, 20, 0, 120, 4, 40, 0, 0, 0,
                    4, 0, 0, 0, 0, 0, 0);
    vecs[1] = mkvec(4'b1111, 5, 8, 3, 80, 5, 10, 5, 5, 5,
                    5, 3, 0, 1, 2, 3, 0);
    vecs[2] = mkvec(4'b0101, 5, 8, 3, 66, 4, 10, 0, 10, 0,
                    4, 3, 0, 2, 0, 2, 0);
    vecs[3] = mkvec(4'b1000, 3, 0, 0, 20, 5, 0, 0, 0, 15,
                    5, 0, 3, 3, 3, 3, 3);
    vecs[4] = mkvec(4'b1111, 0, 5, 2, 20, 0, 0, 0, 0, 0,
                    0, 255, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // async reset mid-ON, then pointer restarts at channel 0
    chan_en = 4'b0010; ton = 16'd10; ts = 16'd20; dt = '0;
    power_start = 1'b1; silk_reach = 1'b1;
    do_reset();
    pulse(0, 0, 0, 0, ch, len, pd_seen, sa_seen);
    chk("pre_rst_ch", 32'(ch), 1);
    pulse(0, 0, 3, 0, ch, len, pd_seen, sa_seen);
    @(negedge clk);
    chan_en = 4'b0010;
    do_reset();
    chan_en = 4'b0010;
    repeat (2) @(negedge clk);
    chk("pre_rst2_gate", 32'(gate), 32'(4'b0010));
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_gate", 32'(gate), 0);
    chk("async_rst_cut", 32'(cut), 0);
    chk("async_rst_busy", 32'(busy), 0);
    chan_en = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    pulse(0, 0, 0, 0, ch, len, pd_seen, sa_seen);
    chk("post_rst_first_ch", 32'(ch), 0);

    // ton change mid-pulse only affects the next grant
    chan_en = 4'b0101; ton = 16'd5; ts = 16'd8; dt = 7'd3;
    do_reset();
    pulse(2, 7, 0, 0, ch, len, pd_seen, sa_seen);
    chk("tonchg_ch_a", 32'(ch), 0);
    chk("tonchg_len_a", 32'(len), 5);
    pulse(0, 0, 0, 0, ch, len, pd_seen, sa_seen);
    chk("tonchg_ch_b", 32'(ch), 2);
    chk("tonchg_len_b", 32'(len), 7);
    pulse(0, 0, 0, 0, ch, len, pd_seen, sa_seen);
    chk("tonchg_ch_c", 32'(ch), 0);

    // short abort at 4th ON cycle, then silk_reach drop in ON
    chan_en = 4'b0001; ton = 16'd10; ts = 16'd4; dt = '0;
    do_reset();
    pulse(0, 0, 4, 0, ch, len, pd_seen, sa_seen);
    chk("short_len", 32'(len), 4);
    chk("short_abort_seen", 32'(sa_seen), 1);
    chk("short_no_pd", 32'(pd_seen), 0);
    c_cut = 0;
    while (cut && c_cut < 600) begin
      c_cut++;
      @(negedge clk);
    end
    chk("short_cut_cycles", 32'(c_cut), SOFF);
    chk("short_regrant_gate", 32'(gate), 1);
    pulse(0, 0, 0, 0, ch, len, pd_seen, sa_seen);
    chk("post_short_len", 32'(len), 10);
    chk("post_short_pd", 32'(pd_seen), 1);
    pulse(0, 0, 0, 3, ch, len, pd_seen, sa_seen);
    chk("drop_len", 32'(len), 3);
    chk("drop_no_pd", 32'(pd_seen), 0);
    chk("drop_busy", 32'(busy), 0);
`ifdef PULSE_STATS_EN
    chk("stats_pulse_cnt", pulse_cnt, 1);
    chk("stats_short_cnt", 32'(short_cnt), 1);
    stats_clr = 1'b1;
    @(negedge clk);
    stats_clr = 1'b0;
    chk("stats_clr_pulse", pulse_cnt, 0);
    chk("stats_clr_short", 32'(short_cnt), 0);
`endif
    silk_reach = 1'b1;

    // randomized run against the model
    chan_en = 4'b1111; ton = 16'd3; ts = 16'd2; dt = 7'd1;
    power_start = 1'b1; silk_reach = 1'b1; short_flag = 1'b0;
    m_reset();
    do_reset();
    clr_now = 0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk);
      m_step(clr_now);
      #1;
      power_start = ($urandom_range(199) != 0);
      silk_reach  = ($urandom_range(199) != 0);
      short_flag  = ($urandom_range(299) == 0);
      if ($urandom_range(19) == 0) chan_en = 4'($urandom_range(15));
      if ($urandom_range(19) == 0) ton = 16'($urandom_range(6));
      if ($urandom_range(19) == 0) ts = 16'($urandom_range(5));
      if ($urandom_range(19) == 0) dt = 7'($urandom_range(3));
      clr_now = ($urandom_range(499) == 0);
`ifdef PULSE_STATS_EN
      stats_clr = clr_now;
`endif
      @(negedge clk);
      chk($sformatf("rnd%0d gate", k), 32'(gate),
          (m_ph == M_ON) ? 32'(1 << m_ch) : 0);
      chk($sformatf("rnd%0d cut", k), 32'(cut), 32'(m_ph == M_SOFF));
      chk($sformatf("rnd%0d busy", k), 32'(busy),
          32'(m_ph != M_IDLE));
      chk($sformatf("rnd%0d cur_ch", k), 32'(cur_ch), 32'(m_ch));
      chk($sformatf("rnd%0d pulse_done", k), 32'(pulse_done),
          32'(m_pd()));
      chk($sformatf("rnd%0d short_abort", k), 32'(short_abort),
          32'(m_sa()));
`ifdef PULSE_STATS_EN
      chk($sformatf("rnd%0d pulse_cnt", k), pulse_cnt, 32'(m_pcnt));
      chk($sformatf("rnd%0d short_cnt", k), 32'(short_cnt),
          32'(m_scnt));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
